// File: rtl/even_odd_classifier_if.sv
// Operand/result handshake bundle for even_odd_classifier.
// The slave modport is the classifier's view; the master modport is the producer/consumer side.
interface even_odd_classifier_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             out_flag;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_flag
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_flag
    );
endinterface

// File: rtl/even_odd_classifier.sv
// Streaming even/odd and divisible-by-DIVISOR classifier, one operand in flight.
// Optional mode-0 result statistics are enabled with the EOC_STATS_EN macro.
module even_odd_classifier #(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 3,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    even_odd_classifier_if.slave   bus,
    output logic                   busy_o
`ifdef EOC_STATS_EN
    ,
    output logic [CNT_W-1:0]       even_count_o,
    output logic [CNT_W-1:0]       odd_count_o
`endif
);

    localparam int R_W   = $clog2(DIVISOR);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [R_W:0]     DIV_T    = (R_W+1)'(DIVISOR);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    if (WIDTH < 2 || DIVISOR < 2 || longint'(DIVISOR) >= (64'd1 << WIDTH) || CNT_W < 1) begin : g_bad_param
        $error("even_odd_classifier: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic             mode_q;
    logic             flag_q;
    logic             valid_q;
    logic             busy_q;
    logic [R_W-1:0]   r_q;
    logic [IDX_W-1:0] idx_q;

    logic             accept_s;
    logic [R_W:0]     t_s;
    logic [R_W-1:0]   rem_d;

    assign bus.in_ready = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.out_ready);
    assign accept_s     = bus.in_valid & bus.in_ready;

    // One MSB-first long-division step: t < 2*DIVISOR, so one conditional subtract is enough.
    always_comb begin
        t_s   = {r_q, data_q[idx_q]};
        rem_d = {R_W{1'b0}};
        if (t_s >= DIV_T) begin
            rem_d = R_W'(t_s - DIV_T);
        end else begin
            rem_d = t_s[R_W-1:0];
        end
    end

    // Control FSM with registered result and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= {WIDTH{1'b0}};
            mode_q  <= 1'b0;
            flag_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            r_q     <= {R_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            data_q <= bus.in_data;
            mode_q <= bus.in_mode;
            r_q    <= {R_W{1'b0}};
            idx_q  <= IDX_LAST;
            if (bus.in_mode) begin
                state_q <= ST_CALC;
                valid_q <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                state_q <= ST_HOLD;
                flag_q  <= ~bus.in_data[0];
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                ST_CALC: begin
                    r_q <= rem_d;
                    if (idx_q == {IDX_W{1'b0}}) begin
                        state_q <= ST_HOLD;
                        flag_q  <= (rem_d == {R_W{1'b0}});
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_mode  = mode_q;
    assign bus.out_flag  = flag_q;
    assign busy_o        = busy_q;

`ifdef EOC_STATS_EN
    logic [CNT_W-1:0] even_cnt_q;
    logic [CNT_W-1:0] odd_cnt_q;
    logic             stat_xfer_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    assign stat_xfer_s = valid_q & bus.out_ready & ~mode_q;

    // Saturating counts of delivered mode-0 results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            even_cnt_q <= {CNT_W{1'b0}};
            odd_cnt_q  <= {CNT_W{1'b0}};
        end else if (stat_xfer_s) begin
            if (flag_q) begin
                even_cnt_q <= sat_inc(even_cnt_q);
            end else begin
                odd_cnt_q <= sat_inc(odd_cnt_q);
            end
        end else begin
            even_cnt_q <= even_cnt_q;
            odd_cnt_q  <= odd_cnt_q;
        end
    end

    assign even_count_o = even_cnt_q;
    assign odd_count_o  = odd_cnt_q;
`endif

endmodule

// File: tb/tb_even_odd_classifier.sv
// Directed plus randomized checks of even_odd_classifier against an arithmetic reference model.
module tb_even_odd_classifier;

    localparam int WIDTH   = 8;
    localparam int DIVISOR = 3;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef EOC_STATS_EN
    logic [CNT_W-1:0] even_count;
    logic [CNT_W-1:0] odd_count;
`endif

    int checks   = 0;
    int failures = 0;

    even_odd_classifier_if #(.WIDTH(WIDTH)) bus ();

    even_odd_classifier #(
        .WIDTH  (WIDTH),
        .DIVISOR(DIVISOR),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy_o      (busy)
`ifdef EOC_STATS_EN
        ,
        .even_count_o(even_count),
        .odd_count_o (odd_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic ref_flag(input int d, input logic m);
        if (m) return (d % DIVISOR) == 0;
        return (d % 2) == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Send one operand from IDLE, wait for its result and check latency, busy time and payload.
    task automatic run_one(input logic [WIDTH-1:0] d, input logic m, input string tag);
        int lat;
        int busy_cycles;
        lat = 0;
        busy_cycles = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.out_ready = 1'b1;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            if (busy) busy_cycles++;
            cyc();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), m ? 32'(WIDTH + 1) : 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_cycles), m ? 32'(WIDTH) : 32'd0);
        chk({tag, "_flag"}, 32'(bus.out_flag), 32'(ref_flag(int'(d), m)));
        chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
        chk({tag, "_mode"}, 32'(bus.out_mode), 32'(m));
        cyc();
        chk({tag, "_idle"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        logic             rm;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) cyc();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_flag",  32'(bus.out_flag),  32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_mode",  32'(bus.out_mode),  32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back mode 0: 6 then 7.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_data   = 8'd6;
        cyc();
        chk("b2b_6_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_6_flag",  32'(bus.out_flag),  32'd1);
        chk("b2b_6_data",  32'(bus.out_data),  32'd6);
        chk("b2b_in_ready_hold", 32'(bus.in_ready), 32'd1);
        bus.in_data = 8'd7;
        cyc();
        chk("b2b_7_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_7_flag",  32'(bus.out_flag),  32'd0);
        chk("b2b_7_data",  32'(bus.out_data),  32'd7);
        bus.in_valid = 1'b0;
        cyc();
        chk("b2b_idle", 32'(bus.out_valid), 32'd0);

        // Mode 1 directed and boundary operands.
        run_one(8'd201, 1'b1, "div_201");
        run_one(8'd200, 1'b1, "div_200");
        run_one(8'd0,   1'b1, "div_0");
        run_one(8'd255, 1'b1, "div_255");
        run_one(8'd254, 1'b1, "div_254");
        run_one(8'd0,   1'b0, "eo_0");
        run_one(8'd255, 1'b0, "eo_255");

        // Exhaustive mode 1.
        for (int i = 0; i < 256; i++) begin
            run_one(WIDTH'(i), 1'b1, "exh");
        end

        // Randomized operands and modes.
        for (int i = 0; i < 60; i++) begin
            rd = WIDTH'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            run_one(rd, rm, "rand");
        end

        // Backpressure in HOLD, then release together with a new operand.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_data   = 8'd10;
        cyc();
        bus.out_ready = 1'b0;
        bus.in_data   = 8'd33;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
            chk("bp_valid",    32'(bus.out_valid), 32'd1);
            chk("bp_data",     32'(bus.out_data),  32'd10);
            chk("bp_flag",     32'(bus.out_flag),  32'd1);
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_next_data",  32'(bus.out_data),  32'd33);
        chk("bp_next_flag",  32'(bus.out_flag),  32'd0);
        bus.in_valid = 1'b0;
        cyc();
        chk("bp_idle", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset during the 4th CALC cycle.
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b1;
        bus.in_data  = 8'd100;
        cyc();
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy),          32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        run_one(8'd81, 1'b1, "after_rst_81");
        run_one(8'd82, 1'b1, "after_rst_82");

`ifdef EOC_STATS_EN
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("stat_even_reset", 32'(even_count), 32'd0);
        chk("stat_odd_reset",  32'(odd_count),  32'd0);
        for (int i = 0; i < 20; i++) run_one(WIDTH'(2 * i), 1'b0, "stat_even");
        for (int i = 0; i < 3; i++)  run_one(WIDTH'(2 * i + 1), 1'b0, "stat_odd");
        chk("stat_even_sat", 32'(even_count), 32'd15);
        chk("stat_odd",      32'(odd_count),  32'd3);
        run_one(8'd9, 1'b1, "stat_m1");
        run_one(8'd7, 1'b1, "stat_m1b");
        chk("stat_even_m1", 32'(even_count), 32'd15);
        chk("stat_odd_m1",  32'(odd_count),  32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
